demux_1ton_collect: RTL and testbench

//  Inverse of muxNto1: routes a 1-bit input stream back into an N-bit word.

---
 rtl/demux_1ton_collect_if.sv | 27 ++
 rtl/demux_1ton_collect.sv | 145 ++++++++++++++
 tb/tb_demux_1ton_collect.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_1ton_collect_if.sv
// Handshake/bus bundle for demux_1ton_collect: serial input side, word output
// side and status flags. The slave modport is the demux; master is its peer.
interface demux_1ton_collect_if #(
  parameter int N         = 8,
  parameter int SEL_WIDTH = $clog2(N)
);
  logic                 In;
  logic                 In_valid;
  logic [SEL_WIDTH-1:0] Sel;
  logic                 Mode;
  logic                 Clear;
  logic [N-1:0]         Out;
  logic                 Out_valid;
  logic                 Out_ready;
  logic                 Busy;
  logic                 Overflow;

  modport slave (
    input  In, In_valid, Sel, Mode, Clear, Out_ready,
    output Out, Out_valid, Busy, Overflow
  );

  modport master (
    output In, In_valid, Sel, Mode, Clear, Out_ready,
    input  Out, Out_valid, Busy, Overflow
  );
endinterface

// File: rtl/demux_1ton_collect.sv
// demux_1ton_collect: turns a 1-bit stream back into an N-bit word.
// Addressed mode writes In straight into Out[Sel]; scan mode assembles N
// valid bits LSB first in a shadow register and presents the finished word
// on a valid/ready handshake. Overflow flags a word lost to backpressure.
module demux_1ton_collect #(
  parameter int N         = 8,
  parameter int SEL_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_1ton_collect_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N - 1);
  localparam logic [SEL_WIDTH-1:0] ONE_IDX  = SEL_WIDTH'(1);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] idx_q, idx_d;
  // Only bits 0..N-2 need storing: the last bit goes straight into Out.
  logic [N-2:0]         shadow_q, shadow_d;
  logic [N-1:0]         out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;

  logic accept;
  logic blocked;

  // Consumer takes the current word this cycle.
  assign accept  = out_valid_q && bus.Out_ready;
  // A word finishing now would overwrite one still waiting to be taken.
  assign blocked = out_valid_q && !bus.Out_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      // NOTE: shadow is a handful of flops, not a RAM, so it is reset with the rest.
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register updates from pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state logic: Clear beats the handshake, which beats new input.
  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch appears.
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;

    if (bus.Clear) begin
      // Abort: drop any partial word and the presented word; Overflow survives.
      state_d     = IDLE;
      idx_d       = '0;
      shadow_d    = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        out_valid_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (bus.In_valid) begin
            if (bus.Mode) begin
              shadow_d[0] = bus.In;
              idx_d       = ONE_IDX;
              state_d     = COLLECT;
            end else begin
              // Addressed write; an out-of-range Sel matches no lane.
              for (int i = 0; i < N; i++) begin
                if (bus.Sel == SEL_WIDTH'(i)) begin
                  out_d[i] = bus.In;
                end
              end
            end
          end
        end

        COLLECT: begin
          if (bus.In_valid) begin
            if (idx_q == LAST_IDX) begin
              if (!blocked) begin
                out_d       = {bus.In, shadow_q};
                out_valid_d = 1'b1;
              end else begin
                overflow_d  = 1'b1;
              end
              idx_d   = '0;
              state_d = HOLD;
            end else begin
              for (int i = 0; i < N - 1; i++) begin
                if (idx_q == SEL_WIDTH'(i)) begin
                  shadow_d[i] = bus.In;
                end
              end
              idx_d = idx_q + ONE_IDX;
            end
          end
        end

        HOLD: begin
          if (bus.In_valid) begin
            // Back-to-back: first bit of the next word while the old one waits.
            shadow_d[0] = bus.In;
            idx_d       = ONE_IDX;
            state_d     = COLLECT;
          end else if (!out_valid_d) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.Out       = out_q;
  assign bus.Out_valid = out_valid_q;
  assign bus.Busy      = (state_q == COLLECT);
  assign bus.Overflow  = overflow_q;

endmodule

// File: tb/tb_demux_1ton_collect.sv
// Bench for demux_1ton_collect: directed scenarios followed by random traffic,
// every cycle compared against a word-level model built on a bit queue.
module tb_demux_1ton_collect;

  localparam int N  = 8;
  localparam int SW = $clog2(N);

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  demux_1ton_collect_if #(.N(N), .SEL_WIDTH(SW)) bus ();

  demux_1ton_collect #(.N(N), .SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits of the word in progress, presented word, flags.
  logic       m_bits[$];
  logic [N-1:0] m_out;
  logic       m_valid;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the model, using the inputs that were stable at the edge.
  task automatic model_step(input logic in_b, input logic vld, input logic [SW-1:0] sel,
                            input logic md, input logic clr, input logic rdy);
    logic         pre_valid;
    logic [N-1:0] word;
    pre_valid = m_valid;
    if (clr) begin
      m_bits.delete();
      m_out   = '0;
      m_valid = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (vld) begin
        if (m_bits.size() == 0 && !pre_valid && !md) begin
          if (int'(sel) < N) m_out[sel] = in_b;
        end else begin
          m_bits.push_back(in_b);
          if (m_bits.size() == N) begin
            word = '0;
            for (int i = 0; i < N; i++) word[i] = m_bits[i];
            if (!(pre_valid && !rdy)) begin
              m_out   = word;
              m_valid = 1'b1;
            end else begin
              m_ovf = 1'b1;
            end
            m_bits.delete();
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"},   32'(bus.Out),       32'(m_out));
    check({tag, ".valid"}, 32'(bus.Out_valid), 32'(m_valid));
    check({tag, ".busy"},  32'(bus.Busy),      32'(m_bits.size() > 0));
    check({tag, ".ovf"},   32'(bus.Overflow),  32'(m_ovf));
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic step(input logic in_b, input logic vld, input logic [SW-1:0] sel,
                      input logic md, input logic clr, input logic rdy, input string tag);
    bus.In        = in_b;
    bus.In_valid  = vld;
    bus.Sel       = sel;
    bus.Mode      = md;
    bus.Clear     = clr;
    bus.Out_ready = rdy;
    @(posedge clk);
    model_step(in_b, vld, sel, md, clr, rdy);
    #1;
    compare_all(tag);
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap, input logic rdy, input string tag);
    for (int i = 0; i < N; i++) begin
      step(w[i], 1'b1, SW'($urandom_range(0, N - 1)), 1'b1, 1'b0, rdy, tag);
      if (i < N - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, rdy, tag);
      end
    end
  endtask

  function automatic logic mux_n_to_1(input logic [N-1:0] d, input logic [SW-1:0] sel);
    return d[sel];
  endfunction

  initial begin
    logic [N-1:0] lb;
    bus.In = 1'b0; bus.In_valid = 1'b0; bus.Sel = '0; bus.Mode = 1'b0;
    bus.Clear = 1'b0; bus.Out_ready = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #1;
    check("rst.out",   32'(bus.Out), 32'h0);
    check("rst.valid", 32'(bus.Out_valid), 32'h0);
    check("rst.busy",  32'(bus.Busy), 32'h0);
    check("rst.ovf",   32'(bus.Overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Addressed mode.
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "addr");
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "addr");
    step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, "addr");
    step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, "addr");
    check("addr.word", 32'(bus.Out), 32'hA5);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "addr");
    check("addr.clr2", 32'(bus.Out), 32'hA1);
    check("addr.novalid", 32'(bus.Out_valid), 32'h0);

    // Scan mode, no gaps then 3-cycle gaps; valid lasts one cycle with ready=1.
    send_word(8'b0100_1101, 0, 1'b1, "scan");
    check("scan.word",  32'(bus.Out), 32'h4D);
    check("scan.valid", 32'(bus.Out_valid), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "scan");
    check("scan.pulse", 32'(bus.Out_valid), 32'h0);
    send_word(8'b0100_1101, 3, 1'b1, "gap");
    check("gap.word", 32'(bus.Out), 32'h4D);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "gap");

    // Backpressure and sticky overflow.
    send_word(8'hA5, 0, 1'b0, "bp");
    check("bp.first", 32'(bus.Out), 32'hA5);
    send_word(8'h3C, 0, 1'b0, "bp");
    check("bp.kept", 32'(bus.Out), 32'hA5);
    check("bp.ovf",  32'(bus.Overflow), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "bp");
    check("bp.drop",   32'(bus.Out_valid), 32'h0);
    check("bp.sticky", 32'(bus.Overflow), 32'h1);

    // Clear mid-word with a concurrent valid bit.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b1, "clr");
    step(1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b1, "clr");
    check("clr.out",  32'(bus.Out), 32'h0);
    check("clr.busy", 32'(bus.Busy), 32'h0);
    check("clr.ovf",  32'(bus.Overflow), 32'h1);
    send_word(8'hFF, 0, 1'b1, "clr");
    check("clr.word", 32'(bus.Out), 32'hFF);

    // Asynchronous reset mid-COLLECT (five bits in), checked before any edge.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, "pre");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b1, "pre");
    check("pre.busy", 32'(bus.Busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.out",   32'(bus.Out), 32'h0);
    check("arst.valid", 32'(bus.Out_valid), 32'h0);
    check("arst.busy",  32'(bus.Busy), 32'h0);
    check("arst.ovf",   32'(bus.Overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loopback from a muxNto1 sweeping Sel over D.
    lb = 8'hC3;
    for (int s = 0; s < N; s++) step(mux_n_to_1(lb, SW'(s)), 1'b1, SW'(s), 1'b1, 1'b0, 1'b0, "loop");
    check("loop.word", 32'(bus.Out), 32'hC3);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "loop");

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 7),
           SW'($urandom_range(0, N - 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 6),
           "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
